// File: rtl/btn_debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
// State encoding, board clock and default debounce time.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_t;

  localparam int CLK_HZ      = 25_000_000;
  localparam int DEBOUNCE_MS = 10;

  // 10 ms at 25 MHz = 250000 cycles
  localparam int DEF_DEBOUNCE_CYCLES =
    (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/btn_debounce_sync_ff.sv
// sync_ff: STAGES-deep flop chain for an asynchronous pin.
// Ports: clk, rst_n (async, active-low), i_d (raw), o_q (synced).
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: sync + stability FSM giving a clean level and edge pulses.
// Ports: clk, rst_n, btn_in (raw) -> level, rise, fall, busy (registered).
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_sync;
  logic          w_s;
  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic          r_busy;
  logic          w_level_nx;
  logic          w_rise_nx;
  logic          w_fall_nx;
  logic          w_busy_nx;

  // Reset loads the inactive pin value so s starts at 0.
  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn_in),
    .o_q   (w_sync)
  );

  assign w_s = w_sync ^ ACTIVE_LOW;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = '0;
    w_level_nx = r_level;
    w_rise_nx  = 1'b0;
    w_fall_nx  = 1'b0;
    unique case (r_state)
      IDLE_LOW: begin
        if (w_s) w_state_nx = CHECK_HIGH;
      end
      CHECK_HIGH: begin
        if (!w_s) begin
          w_state_nx = IDLE_LOW;
        end else if (r_cnt == LAST) begin
          w_state_nx = IDLE_HIGH;
          w_level_nx = 1'b1;
          w_rise_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!w_s) w_state_nx = CHECK_LOW;
      end
      CHECK_LOW: begin
        if (w_s) begin
          w_state_nx = IDLE_HIGH;
        end else if (r_cnt == LAST) begin
          w_state_nx = IDLE_LOW;
          w_level_nx = 1'b0;
          w_fall_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
    endcase
    w_busy_nx = (w_state_nx == CHECK_HIGH) ||
                (w_state_nx == CHECK_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_level <= w_level_nx;
      r_rise  <= w_rise_nx;
      r_fall  <= w_fall_nx;
      r_busy  <= w_busy_nx;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign busy  = r_busy;

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random pin activity
// compared each cycle against a run-length reference model.
module tb_btn_debounce;

  localparam int DEB = 4;
  localparam int SB  = 2;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic btn    = 1'b0;
  logic btn_al = 1'b1;

  logic lv0, ri0, fa0, bu0;
  logic lv1, ri1, fa1, bu1;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state, index 0 = active-high, 1 = active-low
  logic [SB-1:0] m_pipe  [2];
  logic          m_level [2];
  logic          m_rise  [2];
  logic          m_fall  [2];
  logic          m_busy  [2];
  int            m_run   [2];

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SB),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn),
    .level  (lv0),
    .rise   (ri0),
    .fall   (fa0),
    .busy   (bu0)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEB),
    .SYNC_STAGES     (SB),
    .ACTIVE_LOW      (1'b1)
  ) dut_al (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_in (btn_al),
    .level  (lv1),
    .rise   (ri1),
    .fall   (fa1),
    .busy   (bu1)
  );

  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_pipe[d]  = (d == 1) ? {SB{1'b1}} : {SB{1'b0}};
      m_level[d] = 1'b0;
      m_rise[d]  = 1'b0;
      m_fall[d]  = 1'b0;
      m_busy[d]  = 1'b0;
      m_run[d]   = 0;
    end
  endtask

  // A level flips once the normalized sample has disagreed with it
  // on DEB+1 consecutive edges (one to notice, DEB to qualify).
  task automatic m_edge(input int d, input logic pin);
    logic s;
    s = m_pipe[d][SB-1] ^ (d == 1);
    m_rise[d] = 1'b0;
    m_fall[d] = 1'b0;
    if (s != m_level[d]) begin
      m_run[d]++;
      if (m_run[d] == DEB + 1) begin
        m_level[d] = s;
        m_rise[d]  = s;
        m_fall[d]  = ~s;
        m_run[d]   = 0;
      end
    end else begin
      m_run[d] = 0;
    end
    m_busy[d] = (m_run[d] != 0);
    m_pipe[d] = {m_pipe[d][SB-2:0], pin};
  endtask

  task automatic chk_all();
    chk("m_level", lv0, m_level[0]);
    chk("m_rise",  ri0, m_rise[0]);
    chk("m_fall",  fa0, m_fall[0]);
    chk("m_busy",  bu0, m_busy[0]);
    chk("al_level", lv1, m_level[1]);
    chk("al_rise",  ri1, m_rise[1]);
    chk("al_fall",  fa1, m_fall[1]);
    chk("al_busy",  bu1, m_busy[1]);
    chk("excl", ri0 & fa0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    m_edge(0, btn);
    m_edge(1, btn_al);
    #1;
    chk_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lv"}, lv0, 1'b0);
    chk({tag, "_ri"}, ri0, 1'b0);
    chk({tag, "_fa"}, fa0, 1'b0);
    chk({tag, "_bu"}, bu0, 1'b0);
    chk({tag, "_lv_al"}, lv1, 1'b0);
    chk({tag, "_bu_al"}, bu1, 1'b0);
  endtask

  initial begin
    logic [4:0] bounce;
    int hold;
    m_reset();
    #5;
    chk_zero("reset");
    #25 rst_n = 1'b1;
    steps(3);

    // clean press: edge 0 is the first step after btn rises
    btn = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step();
      chk("press_level", lv0, e >= 6);
      chk("press_rise",  ri0, e == 6);
      chk("press_busy",  bu0, (e >= 2) && (e <= 5));
      chk("press_fall",  fa0, 1'b0);
    end

    // release
    btn = 1'b0;
    for (int e = 0; e < 9; e++) begin
      step();
      chk("rel_level", lv0, e < 6);
      chk("rel_fall",  fa0, e == 6);
      chk("rel_rise",  ri0, 1'b0);
    end
    steps(2);

    // bounce 1,0,1,0 then final 1 held
    bounce = 5'b01010;
    for (int i = 0; i < 4; i++) begin
      btn = bounce[3-i];
      step();
      chk("bounce_rise", ri0, 1'b0);
    end
    btn = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step();
      chk("bounce_level", lv0, e >= 6);
      chk("bounce_rise2", ri0, e == 6);
    end
    btn = 1'b0;
    steps(10);
    chk("back_low", lv0, 1'b0);

    // short glitch of 3 cycles
    btn = 1'b1;
    steps(3);
    btn = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step();
      chk("glitch_level", lv0, 1'b0);
      chk("glitch_rise",  ri0, 1'b0);
    end
    chk("glitch_busy", bu0, 1'b0);

    // reset while qualifying with counter at 2
    btn = 1'b1;
    steps(5);
    chk("mid_busy", bu0, 1'b1);
    #10 rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    m_reset();
    #5 rst_n = 1'b1;
    for (int e = 0; e < 9; e++) begin
      step();
      chk("rst_rise",  ri0, e == 6);
      chk("rst_level", lv0, e >= 6);
    end
    btn = 1'b0;
    steps(10);

    // active-low pin: pressed = driven low
    chk("al_idle", lv1, 1'b0);
    btn_al = 1'b0;
    for (int e = 0; e < 9; e++) begin
      step();
      chk("al_press_level", lv1, e >= 6);
      chk("al_press_rise",  ri1, e == 6);
      chk("al_press_fall",  fa1, 1'b0);
    end
    btn_al = 1'b1;
    steps(10);
    chk("al_released", lv1, 1'b0);

    // random pin activity with occasional resets
    for (int k = 0; k < 120; k++) begin
      btn    = 1'($urandom_range(0, 1));
      btn_al = 1'($urandom_range(0, 1));
      hold   = $urandom_range(1, 9);
      steps(hold);
      if ($urandom_range(0, 24) == 0) begin
        #10 rst_n = 1'b0;
        #1;
        chk_zero("rnd_rst");
        m_reset();
        #5 rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
